// File: rtl/i2d_bus_arb.sv
// ---------------------------------------------------------------------------
// i2d_bus_arb
//
// Shares the single Wishbone master port of the i2d core between the
// instruction-fetch unit (IF) and the load/store unit (LS). Round-robin
// arbitration with one outstanding transaction at a time. Slave retries are
// tolerated up to MAX_RETRY times, and a silent slave is abandoned after
// TIMEOUT strobe cycles. The outcome is returned to the winning requester as a
// one-cycle ack or err pulse.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   if_req/if_adr                 IF read request and fetch address
//   if_dat/if_ack/if_err          IF read data, completion, failure
//   ls_req/ls_we/ls_sel/ls_adr    LS request, direction, lanes, address
//   ls_wdat                       LS write data
//   ls_rdat/ls_ack/ls_err         LS read data, completion, failure
//   cyc_o/stb_o/we_o/sel_o        Wishbone master control
//   adr_o/dat_o                   Wishbone address and write data
//   dat_i/ack_i/rty_i/err_i       Wishbone slave data and responses
// ---------------------------------------------------------------------------
module i2d_bus_arb #(
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 255    // 1..255, counter is 8 bits
) (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch requester
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic [31:0] if_dat,
    output logic        if_ack,
    output logic        if_err,
    // load/store requester
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_sel,
    input  logic [31:0] ls_adr,
    input  logic [31:0] ls_wdat,
    output logic [31:0] ls_rdat,
    output logic        ls_ack,
    output logic        ls_err,
    // Wishbone master port
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        rty_i,
    input  logic        err_i
);

    localparam int              RCW       = $clog2(MAX_RETRY + 1);
    localparam logic [RCW-1:0]  RTY_LIMIT = RCW'(MAX_RETRY);
    localparam logic [7:0]      TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RETRY,
        S_DONE
    } state_t;

    // The owner register is both the current winner and the last_grant used
    // for the round-robin tie break.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    state_t         state;
    owner_t         owner;
    logic [RCW-1:0] rty_cnt;
    logic [7:0]     tmo_cnt;

    logic pick_ls;
    logic resp_ack;
    logic resp_rty;
    logic no_resp;
    logic bus_fail;

    // LS wins when it is the only requester, or on a tie when IF was granted last.
    assign pick_ls  = ls_req & (~if_req | (owner == OWN_IF));

    // Response priority err_i > ack_i > rty_i.
    assign resp_ack = ack_i & ~err_i;
    assign resp_rty = rty_i & ~ack_i & ~err_i;
    assign no_resp  = ~(ack_i | rty_i | err_i);

    // Any of: slave error, retry budget exhausted, silent slave at the timeout.
    assign bus_fail = err_i
                    | (resp_rty & (rty_cnt == RTY_LIMIT))
                    | (no_resp  & (tmo_cnt == TMO_LAST));

    // NOTE: all state is updated with non-blocking assignments so every branch
    // sees the pre-edge values; the datapath registers are reset too because
    // every output must read 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner   <= OWN_IF;
            rty_cnt <= '0;
            tmo_cnt <= '0;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            sel_o   <= '0;
            adr_o   <= '0;
            dat_o   <= '0;
            if_dat  <= '0;
            if_ack  <= 1'b0;
            if_err  <= 1'b0;
            ls_rdat <= '0;
            ls_ack  <= 1'b0;
            ls_err  <= 1'b0;
        end else begin
            // Completion flags are pulses: cleared every cycle unless BUS
            // sets one on its way into DONE.
            if_ack <= 1'b0;
            if_err <= 1'b0;
            ls_ack <= 1'b0;
            ls_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (if_req | ls_req) begin
                        if (pick_ls) begin
                            owner <= OWN_LS;
                            we_o  <= ls_we;
                            sel_o <= ls_sel;
                            adr_o <= ls_adr;
                            dat_o <= ls_wdat;
                        end else begin
                            // Instruction fetches are always full-word reads.
                            owner <= OWN_IF;
                            we_o  <= 1'b0;
                            sel_o <= 4'hF;
                            adr_o <= if_adr;
                            dat_o <= '0;
                        end
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        rty_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (bus_fail) begin
                        if (owner == OWN_LS) ls_err <= 1'b1;
                        else                 if_err <= 1'b1;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        state <= S_DONE;
                    end else if (resp_ack) begin
                        if (owner == OWN_LS) begin
                            ls_rdat <= dat_i;
                            ls_ack  <= 1'b1;
                        end else begin
                            if_dat  <= dat_i;
                            if_ack  <= 1'b1;
                        end
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        state <= S_DONE;
                    end else if (resp_rty) begin
                        // Keep the cycle, drop the strobe for one cycle.
                        rty_cnt <= rty_cnt + 1'b1;
                        stb_o   <= 1'b0;
                        state   <= S_RETRY;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                S_RETRY: begin
                    stb_o   <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= S_BUS;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2d_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_i2d_bus_arb
//
// Self-checking bench for i2d_bus_arb. The bench plays both requesters and the
// Wishbone slave. The slave replays a per-transaction script of responses, one
// entry per strobe cycle ({err,ack,rty}; an exhausted script means silence).
// A transaction-level reference model walks the same script with the
// retry/timeout/priority rules and predicts the outcome, the number of strobe
// cycles, the number of retry gaps and the completion latency.
// ---------------------------------------------------------------------------
module tb_i2d_bus_arb;

    localparam int MAX_RETRY = 4;
    localparam int TIMEOUT   = 255;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_RTY  = 3'b001;
    localparam logic [2:0] R_ACK  = 3'b010;
    localparam logic [2:0] R_ERR  = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_adr;
    logic [31:0] if_dat;
    logic        if_ack;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_sel;
    logic [31:0] ls_adr;
    logic [31:0] ls_wdat;
    logic [31:0] ls_rdat;
    logic        ls_ack;
    logic        ls_err;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        rty_i;
    logic        err_i;

    i2d_bus_arb #(
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_adr  (if_adr),
        .if_dat  (if_dat),
        .if_ack  (if_ack),
        .if_err  (if_err),
        .ls_req  (ls_req),
        .ls_we   (ls_we),
        .ls_sel  (ls_sel),
        .ls_adr  (ls_adr),
        .ls_wdat (ls_wdat),
        .ls_rdat (ls_rdat),
        .ls_ack  (ls_ack),
        .ls_err  (ls_err),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .sel_o   (sel_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .rty_i   (rty_i),
        .err_i   (err_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  resp_q[$];
    logic [31:0] slave_rdata;
    bit          model_last_ls;   // requester granted most recently

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drive the slave for the coming
    // rising edge: one script entry is consumed per visible strobe cycle.
    task automatic step();
        logic [2:0] code;
        @(negedge clk);
        if (stb_o) begin
            code = (resp_q.size() > 0) ? resp_q.pop_front() : R_NONE;
            {err_i, ack_i, rty_i} = code;
            dat_i = code[1] ? slave_rdata : $urandom;
        end else begin
            {err_i, ack_i, rty_i} = 3'b000;
            dat_i = $urandom;
        end
    endtask

    // Reference model: walk the response script one strobe cycle at a time.
    function automatic void predict(input logic [2:0] script[$], output bit ok,
                                    output int bus_cyc, output int rtys);
        int silent = 0;
        logic [2:0] code;
        ok = 1'b0;
        bus_cyc = 0;
        rtys = 0;
        for (int i = 0; i < 100000; i++) begin
            code = (i < script.size()) ? script[i] : R_NONE;
            bus_cyc++;
            if (code[2]) begin ok = 1'b0; return; end
            if (code[1]) begin ok = 1'b1; return; end
            if (code[0]) begin
                if (rtys == MAX_RETRY) begin ok = 1'b0; return; end
                rtys++;
                silent = 0;
            end else begin
                silent++;
                if (silent == TIMEOUT) begin ok = 1'b0; return; end
            end
        end
    endfunction

    // One transaction from a single requester against the script in resp_q.
    // Starts and ends on a falling edge with the arbiter idle.
    task automatic run_single(input bit is_ls, input logic we, input logic [3:0] sel,
                              input logic [31:0] adr, input logic [31:0] wdat,
                              input logic [31:0] rdata, input string name);
        logic [2:0]  script[$];
        bit          exp_ok;
        int          exp_bus, exp_rty;
        int          t = 0, ack_t = 0, n_stb = 0, n_gap = 0;
        bit          done = 0, got_ack = 0, got_err = 0, bus_bad = 0, other_pulse = 0;
        logic        my_ack, my_err, exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat, held;

        script = resp_q;
        predict(script, exp_ok, exp_bus, exp_rty);
        slave_rdata = rdata;
        exp_we  = is_ls ? we   : 1'b0;
        exp_sel = is_ls ? sel  : 4'hF;
        exp_dat = is_ls ? wdat : 32'h0;

        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_sel = sel; ls_adr = adr; ls_wdat = wdat;
            if_req = 1'b0;
        end else begin
            if_req = 1'b1; if_adr = adr;
            ls_req = 1'b0;
        end

        while (!done && t < 2000) begin
            step();
            t++;
            // The idle requester's fields wander; they must never reach the bus.
            if (is_ls) if_adr = $urandom;
            else begin
                ls_adr = $urandom; ls_we = 1'($urandom); ls_sel = 4'($urandom); ls_wdat = $urandom;
            end
            my_ack = is_ls ? ls_ack : if_ack;
            my_err = is_ls ? ls_err : if_err;
            if (is_ls ? (if_ack | if_err) : (ls_ack | ls_err)) other_pulse = 1;
            if (stb_o) begin
                n_stb++;
                if ({we_o, sel_o, adr_o, dat_o} !== {exp_we, exp_sel, adr, exp_dat}) bus_bad = 1;
            end else if (cyc_o) begin
                n_gap++;
                if (adr_o !== adr) bus_bad = 1;
            end
            if (my_ack | my_err) begin
                done = 1; got_ack = my_ack; got_err = my_err; ack_t = t;
                check({name, "_cyc_drop"}, {cyc_o, stb_o}, 2'b00);
                if (my_ack) check({name, "_rdata"}, is_ls ? ls_rdat : if_dat, rdata);
                if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
            end
        end

        if (!done) begin
            check({name, "_no_completion"}, 1'b0, 1'b1);
            if_req = 1'b0; ls_req = 1'b0;
        end else begin
            check({name, "_outcome"},  {got_ack, got_err}, exp_ok ? 2'b10 : 2'b01);
            check({name, "_latency"},  ack_t, exp_bus + exp_rty + 1);
            check({name, "_stb_cyc"},  n_stb, exp_bus);
            check({name, "_rty_gaps"}, n_gap, exp_rty);
            check({name, "_bus_fields"}, bus_bad, 1'b0);
            check({name, "_other_pulse"}, other_pulse, 1'b0);
            held = is_ls ? ls_rdat : if_dat;
            step();
            check({name, "_pulse_cleared"}, {cyc_o, stb_o, if_ack, if_err, ls_ack, ls_err}, 6'b0);
            check({name, "_rdata_hold"}, is_ls ? ls_rdat : if_dat, held);
        end
        model_last_ls = is_ls;
        resp_q.delete();
    endtask

    // Both requesters held continuously for n transactions, every one acked on
    // its first strobe. Grants must alternate starting from the model's state.
    task automatic run_both(input int n);
        int   t = 0, grant_t = 0, last_done_t = -1, dones = 0;
        bit   prev_cyc = 0, exp_ls;

        ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'hF; ls_adr = 32'h100; ls_wdat = 32'hDEADBEEF;
        if_req = 1'b1; if_adr = 32'h40;
        slave_rdata = $urandom;
        for (int i = 0; i < n; i++) resp_q.push_back(R_ACK);

        while (dones < n && t < 200) begin
            step();
            t++;
            if (cyc_o && !prev_cyc) begin
                exp_ls = !model_last_ls;
                check("both_grant_adr", adr_o, exp_ls ? 32'h100 : 32'h40);
                check("both_grant_we",  we_o, exp_ls);
                check("both_grant_dat", {sel_o, dat_o}, exp_ls ? {4'hF, 32'hDEADBEEF} : {4'hF, 32'h0});
                if (last_done_t >= 0) check("both_ack_to_grant", t - last_done_t, 2);
                model_last_ls = exp_ls;
                grant_t = t;
            end
            prev_cyc = cyc_o;
            if (ls_ack | if_ack | ls_err | if_err) begin
                check("both_ack_owner", {ls_ack, if_ack, ls_err, if_err},
                      model_last_ls ? 4'b1000 : 4'b0100);
                check("both_ack_latency", t - grant_t, 1);
                last_done_t = t;
                dones++;
                if (dones == n) begin ls_req = 1'b0; if_req = 1'b0; end
            end
        end
        if (dones < n) begin
            check("both_no_completion", dones, n);
            ls_req = 1'b0; if_req = 1'b0;
        end
        step();
        check("both_idle_after", {cyc_o, stb_o}, 2'b00);
        resp_q.delete();
    endtask

    // Random response script: a short burst of mixed responses, usually closed
    // by an ack, occasionally left open so the timeout path is exercised.
    task automatic random_script();
        int n = $urandom_range(0, 6);
        int r;
        resp_q.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 11);
            if (r <= 3)       resp_q.push_back(R_NONE);
            else if (r <= 6)  resp_q.push_back(R_RTY);
            else if (r <= 8)  resp_q.push_back(R_ACK);
            else if (r == 9)  resp_q.push_back(R_ERR);
            else              resp_q.push_back(3'($urandom_range(1, 7)));
        end
        if ($urandom_range(0, 7) != 0) resp_q.push_back(R_ACK);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_adr = 0; ls_req = 0; ls_we = 0; ls_sel = 0; ls_adr = 0; ls_wdat = 0;
        dat_i = 0; ack_i = 0; rty_i = 0; err_i = 0;
        slave_rdata = 0;
        model_last_ls = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {if_dat, ls_rdat, adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, if_ack, if_err, ls_ack, ls_err},
              '0);
        rst = 1'b0;

        // Tie straight after reset goes to LS, then strict alternation.
        run_both(6);

        // Plain IF read acked on the first strobe.
        resp_q = '{R_ACK};
        run_single(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h12345678, "if_read");

        // Four retries then ack; five retries give err.
        resp_q = '{R_RTY, R_RTY, R_RTY, R_RTY, R_ACK};
        run_single(1'b1, 1'b0, 4'h3, 32'h200, 32'h0, 32'hA5A5_0001, "rty4_ack");
        resp_q = '{R_RTY, R_RTY, R_RTY, R_RTY, R_RTY, R_ACK};
        run_single(1'b0, 1'b0, 4'h0, 32'h204, 32'h0, 32'hA5A5_0002, "rty5_err");

        // Silent slave, and silence that restarts after a retry.
        run_single(1'b1, 1'b1, 4'hC, 32'h300, 32'h1111_2222, 32'h0, "timeout");
        for (int i = 0; i < 200; i++) resp_q.push_back(R_NONE);
        resp_q.push_back(R_RTY);
        for (int i = 0; i < 200; i++) resp_q.push_back(R_NONE);
        resp_q.push_back(R_ACK);
        run_single(1'b0, 1'b0, 4'h0, 32'h304, 32'h0, 32'hCAFE_F00D, "tmo_restart");

        // Slave error and the response priority err > ack > rty.
        resp_q = '{R_NONE, R_ERR};
        run_single(1'b1, 1'b0, 4'hF, 32'h400, 32'h0, 32'h0, "slave_err");
        resp_q = '{R_ERR | R_ACK | R_RTY};
        run_single(1'b1, 1'b1, 4'h1, 32'h404, 32'h5, 32'h0, "prio_err");
        resp_q = '{R_ACK | R_RTY};
        run_single(1'b0, 1'b0, 4'h0, 32'h408, 32'h0, 32'h0BAD_BEEF, "prio_ack");

        // Reset in the middle of a bus cycle, then a pending IF fetch.
        if_req = 1'b1; if_adr = 32'h80; ls_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_cyc", {cyc_o, stb_o}, 2'b11);
        #2 rst = 1'b1;
        #1 check("rst_async_drop", {cyc_o, stb_o, if_ack, if_err, ls_ack, ls_err}, 6'b0);
        @(negedge clk);
        check("rst_held_quiet", {cyc_o, stb_o, if_ack, if_err, ls_ack, ls_err}, 6'b0);
        rst = 1'b0;
        model_last_ls = 1'b0;
        resp_q = '{R_ACK};
        run_single(1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 32'h7777_8888, "post_rst_if");

        // The reset also restored last_grant, so a tie goes to LS again.
        run_both(2);

        // Randomised transactions.
        for (int k = 0; k < 40; k++) begin
            random_script();
            run_single(1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
